// File: rtl/mobius_stream_io.sv
// Streaming wrapper around an external combinational Mobius-transform array:
// loads a truth table word by word, waits for the array to settle, captures and drains the ANF.
module mobius_stream_io #(
  parameter int N      = 4096,
  parameter int W      = 32,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic [0:N-1] tt_out,
  input  logic [0:N-1] anf_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         frame_err
);

  localparam int WORDS = N / W;
  localparam int CW    = $clog2(WORDS) + 1;
  localparam int SW    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST_WORD   = CW'(WORDS - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_DONE = SW'(1);

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_CAPTURE, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_settle;
  logic [0:N-1]  r_tt;
  logic [0:N-1]  r_anf;
  logic          r_frameErr;
  logic          w_inFire;
  logic          w_outFire;
  logic          w_lastWord;

  assign w_lastWord = (r_cnt == LAST_WORD);
  assign w_inFire   = in_valid & in_ready;
  assign w_outFire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_lastWord) w_nextState = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle == SETTLE_DONE) w_nextState = S_CAPTURE;
      end
      S_CAPTURE: w_nextState = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && w_lastWord) w_nextState = S_LOAD;
      end
      default: w_nextState = S_LOAD;
    endcase
  end

  // One counter walks the word slots for both loading and draining; frames never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_settle   <= '0;
      r_tt       <= '0;
      r_anf      <= '0;
      r_frameErr <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_inFire) begin
            r_tt[int'(r_cnt)*W +: W] <= in_data;
            if (in_last != w_lastWord) r_frameErr <= 1'b1;
            if (w_lastWord) begin
              r_cnt    <= '0;
              r_settle <= SETTLE_INIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_SETTLE:  r_settle <= r_settle - 1'b1;
        S_CAPTURE: r_anf <= anf_in;
        S_DRAIN: begin
          if (w_outFire) r_cnt <= w_lastWord ? '0 : r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign tt_out    = r_tt;
  assign out_data  = r_anf[int'(r_cnt)*W +: W];
  assign out_last  = (r_state == S_DRAIN) && w_lastWord;
  assign frame_err = r_frameErr;

endmodule

// File: tb/tb_mobius_stream_io.sv
// Randomized bench for mobius_stream_io (N=64, W=8, SETTLE=2) with a behavioural array
// and a subset-sum Mobius reference model.
module tb_mobius_stream_io;

  typedef logic [0:63] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  vec_t       tt_out;
  vec_t       anf_in;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  mobius_stream_io #(.N(64), .W(8), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .tt_out(tt_out), .anf_in(anf_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Stand-in for the external array: in-place butterfly form of the transform.
  function automatic vec_t arrayModel(input vec_t f);
    vec_t a = f;
    for (int s = 1; s < 64; s = s << 1)
      for (int i = 0; i < 64; i++)
        if ((i & s) != 0) a[i] = a[i] ^ a[i ^ s];
    return a;
  endfunction

  assign anf_in = arrayModel(tt_out);

  // Reference: each ANF coefficient is the XOR of the truth table over all subsets of its index.
  function automatic vec_t refMobius(input vec_t f);
    vec_t a = '0;
    for (int u = 0; u < 64; u++)
      for (int x = 0; x < 64; x++)
        if ((x & ~u & 63) == 0) a[u] = a[u] ^ f[x];
    return a;
  endfunction

  function automatic vec_t randVec();
    return {$urandom(), $urandom()};
  endfunction

  // Called at a negedge; returns at a negedge after the last accepted word.
  task automatic sendFrame(input vec_t tt, input int lastAt, input int gapMax, input int nWords);
    logic acc;
    int guard;
    for (int k = 0; k < nWords; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, gapMax)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = tt[k*8 +: 8];
      in_last  = (k == lastAt);
      guard = 0;
      do begin
        acc = in_ready;
        @(posedge clk);
        guard++;
        if (!acc) @(negedge clk);
      end while (!acc && guard < 100);
      if (!acc) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL in_handshake word %0d: in_ready=%0b, required 1 within 100 cycles", k, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recvFrame(input int stallWord, input int readyPct,
                           output vec_t got, output int lastErrs, output int firstLat);
    int k = 0;
    int guard = 0;
    int stall = 0;
    int tStart = cycle;
    logic [7:0] held = '0;
    got = '0;
    lastErrs = 0;
    firstLat = -1;
    while (k < 8 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (out_valid && firstLat < 0) firstLat = cycle - tStart;
      if (k == stallWord && out_valid && stall < 5) begin
        out_ready = 1'b0;
        if (stall == 0) held = out_data;
        else begin
          vectors++;
          if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_hold: data=%h valid=%0b in_ready=%0b, required data=%h valid=1 in_ready=0",
                     out_data, out_valid, in_ready, held);
          end
        end
        stall++;
      end else begin
        out_ready = ($urandom_range(0, 99) < readyPct);
      end
      if (out_valid && out_ready) begin
        got[k*8 +: 8] = out_data;
        if (out_last !== (k == 7)) lastErrs++;
        k++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    if (k < 8) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL out_timeout: words received %0d, required 8", k);
    end
  endtask

  task automatic checkFrame(input string name, input vec_t got, input vec_t exp, input int lastErrs);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s data: got %h, required %h", name, got, exp);
    end
    vectors++;
    if (lastErrs != 0) begin
      miscompares++;
      $display("[TB] FAIL %s out_last: %0d misplaced flags, required 0", name, lastErrs);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
        frame_err !== 1'b0 || tt_out !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: rdy=%0b vld=%0b data=%h last=%0b err=%0b tt=%h, required 1 0 00 0 0 0",
               in_ready, out_valid, out_data, out_last, frame_err, tt_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_delta();
    vec_t tt = 64'h8000_0000_0000_0000;
    vec_t got;
    int le, lat;
    sendFrame(tt, 7, 0, 8);
    recvFrame(-1, 100, got, le, lat);
    checkFrame("delta", got, refMobius(tt), le);
    vectors++;
    if (got !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("[TB] FAIL delta_ones: got %h, required all ones", got);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL delta_err: frame_err=%0b, required 0", frame_err);
    end
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_frame: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_all_ones();
    vec_t tt = 64'hFFFF_FFFF_FFFF_FFFF;
    vec_t got;
    int le, lat;
    sendFrame(tt, 7, 0, 8);
    recvFrame(-1, 100, got, le, lat);
    checkFrame("all_ones", got, refMobius(tt), le);
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("[TB] FAIL latency: first out_valid after %0d cycles, required 3", lat);
    end
  endtask

  task automatic test_backpressure();
    vec_t tt = randVec();
    vec_t got;
    int le, lat;
    sendFrame(tt, 7, 1, 8);
    recvFrame(3, 100, got, le, lat);
    checkFrame("backpressure", got, refMobius(tt), le);
  endtask

  task automatic test_early_last();
    vec_t tt = randVec();
    vec_t tt2 = randVec();
    vec_t got;
    int le, lat;
    sendFrame(tt, 4, 0, 8);
    recvFrame(-1, 100, got, le, lat);
    checkFrame("early_last", got, refMobius(tt), le);
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL early_last_err: frame_err=%0b, required 1", frame_err);
    end
    sendFrame(tt2, 7, 0, 8);
    recvFrame(-1, 80, got, le, lat);
    checkFrame("after_err", got, refMobius(tt2), le);
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_sticky: frame_err=%0b, required 1", frame_err);
    end
  endtask

  task automatic test_mid_reset();
    vec_t tt = randVec();
    vec_t got;
    int le, lat;
    sendFrame(randVec(), 7, 0, 3);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
        frame_err !== 1'b0 || tt_out !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: rdy=%0b vld=%0b data=%h last=%0b err=%0b tt=%h, required 1 0 00 0 0 0",
               in_ready, out_valid, out_data, out_last, frame_err, tt_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendFrame(tt, 7, 1, 8);
    recvFrame(-1, 70, got, le, lat);
    checkFrame("post_reset", got, refMobius(tt), le);
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_err: frame_err=%0b, required 0", frame_err);
    end
  endtask

  task automatic test_missing_last();
    vec_t tt = randVec();
    vec_t got;
    int le, lat;
    sendFrame(tt, -1, 0, 8);
    recvFrame(-1, 100, got, le, lat);
    checkFrame("missing_last", got, refMobius(tt), le);
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL missing_last_err: frame_err=%0b, required 1", frame_err);
    end
  endtask

  task automatic test_back_to_back();
    vec_t tt;
    vec_t got;
    vec_t back;
    int le, lat;
    for (int f = 0; f < 6; f++) begin
      tt = randVec();
      sendFrame(tt, 7, 2, 8);
      recvFrame(-1, 60, got, le, lat);
      checkFrame("random_frame", got, refMobius(tt), le);
      sendFrame(got, 7, 1, 8);
      recvFrame(-1, 60, back, le, lat);
      checkFrame("involution", back, tt, le);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_delta();
    test_all_ones();
    test_backpressure();
    test_early_last();
    test_mid_reset();
    test_missing_last();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
